// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: word width, NOP encoding, the default PC
// increment and the instruction field positions that decode relies on.
package arm_pkg;

    localparam int          WORD_W          = 32;
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;

    // Instruction field positions consumed by the decode stage
    localparam int COND_LSB   = 28;
    localparam int COND_W     = 4;
    localparam int OPCODE_LSB = 21;
    localparam int OPCODE_W   = 4;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: carries the fetched word, its return PC and a
// valid flag into decode. Flush (branch redirect) beats freeze (hazard stall).
module if_id_reg
    import arm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic [WORD_W-1:0] fetch_pc,
    input  logic [WORD_W-1:0] fetch_instr,
    output logic [WORD_W-1:0] id_pc,
    output logic [WORD_W-1:0] id_instr,
    output logic              id_valid
);

    logic [WORD_W-1:0] id_pc_r;
    logic [WORD_W-1:0] id_instr_r;
    logic              id_valid_r;

    // Load, hold or bubble the IF/ID contents; a flush injects a NOP bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_pc_r    <= 32'h0000_0000;
            id_instr_r <= NOP_INSTR;
            id_valid_r <= 1'b0;
        end else if (flush) begin
            id_pc_r    <= 32'h0000_0000;
            id_instr_r <= NOP_INSTR;
            id_valid_r <= 1'b0;
        end else if (freeze) begin
            id_pc_r    <= id_pc_r;
            id_instr_r <= id_instr_r;
            id_valid_r <= id_valid_r;
        end else begin
            id_pc_r    <= fetch_pc;
            id_instr_r <= fetch_instr;
            id_valid_r <= 1'b1;
        end
    end

    assign id_pc    = id_pc_r;
    assign id_instr = id_instr_r;
    assign id_valid = id_valid_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, presents it to the combinational
// instruction ROM, picks the next PC (redirect, stall or sequential) and
// hands the fetched word to decode through the IF/ID register.
module fetch_stage
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_addr,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_instr,
    output logic [WORD_W-1:0] id_pc,
    output logic [WORD_W-1:0] id_instr,
    output logic              id_valid,
    output logic [CNT_W-1:0]  fetch_count
);

    logic [WORD_W-1:0] pc_r;
    logic [CNT_W-1:0]  fetch_count_r;
    logic [WORD_W-1:0] seq_pc_s;
    logic [WORD_W-1:0] next_pc_s;
    logic              load_valid_s;

    // Sequential successor wraps naturally modulo 2^32
    assign seq_pc_s = pc_r + PC_STEP;

    // Next-PC select: a redirect always wins so it is never lost to a stall
    always_comb begin
        next_pc_s    = pc_r;
        load_valid_s = 1'b0;
        if (branch_taken) begin
            next_pc_s    = word_align(branch_addr);
            load_valid_s = 1'b0;
        end else if (freeze) begin
            next_pc_s    = pc_r;
            load_valid_s = 1'b0;
        end else begin
            next_pc_s    = seq_pc_s;
            load_valid_s = 1'b1;
        end
    end

    // Program counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // Count real instructions handed to decode; bubbles and stalls do not count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_r <= {CNT_W{1'b0}};
        end else if (load_valid_s) begin
            fetch_count_r <= fetch_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .flush       (branch_taken),
        .freeze      (freeze),
        .fetch_pc    (seq_pc_s),
        .fetch_instr (imem_instr),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .id_valid    (id_valid)
    );

    assign imem_addr   = pc_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// stall/redirect run compared against a cycle-level reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] imem_addr, imem_instr, id_pc, id_instr;
    logic        id_valid;
    logic [15:0] fetch_count;
    logic [31:0] imem_addr_w, imem_instr_w, id_pc_w, id_instr_w;
    logic        id_valid_w;
    logic [15:0] fetch_count_w;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_id_pc, m_id_instr;
    logic        m_id_valid;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    // Instruction ROM contents: fixed word at 0, unmapped (zero) at xF0-xFF
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0) return 32'hE3A0_0014;
        if (a[7:4] == 4'hF) return 32'h0;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign imem_instr   = rom(imem_addr);
    assign imem_instr_w = rom(imem_addr_w);

    fetch_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid),
        .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_addr(imem_addr_w), .imem_instr(imem_instr_w),
        .id_pc(id_pc_w), .id_instr(id_instr_w), .id_valid(id_valid_w),
        .fetch_count(fetch_count_w)
    );

    task automatic model_reset();
        m_pc = 32'h0; m_id_pc = 32'h0; m_id_instr = 32'h0; m_id_valid = 1'b0; m_cnt = 16'h0;
    endtask

    // One clock of fetch behaviour from the stall/redirect rules
    task automatic model_step(input logic f, input logic b, input logic [31:0] a);
        if (b) begin
            m_pc = a & 32'hFFFF_FFFC;
            m_id_pc = 32'h0; m_id_instr = 32'h0; m_id_valid = 1'b0;
        end else if (!f) begin
            m_id_pc    = m_pc + 32'd4;
            m_id_instr = rom(m_pc);
            m_id_valid = 1'b1;
            m_cnt      = m_cnt + 16'd1;
            m_pc       = m_pc + 32'd4;
        end
    endtask

    // Apply inputs for one cycle, advance model, park on the falling edge
    task automatic drive(input logic f, input logic b, input logic [31:0] a);
        freeze = f; branch_taken = b; branch_addr = a;
        @(posedge clk);
        model_step(f, b, a);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", imem_addr, 32'h0); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
        n_checks++; if (id_instr !== 32'h0 || id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_ifid: got pc %h instr %h expected 0 0", id_pc, id_instr); end
        n_checks++; if (fetch_count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, imem_addr, 32'(4 * i)); end
            n_checks++; if (fetch_count !== 16'(i)) begin n_fail++; $display("FAIL seq_count[%0d]: got %0d expected %0d", i, fetch_count, i); end
            n_checks++; if (id_valid !== (i != 0)) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b expected %b", i, id_valid, (i != 0)); end
            n_checks++; if (i != 0 && id_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_id_pc[%0d]: got %h expected %h", i, id_pc, 32'(4 * i)); end
            drive(1'b0, 1'b0, 32'h0);
            if (i == 0) begin
                n_checks++; if (id_instr !== 32'hE3A0_0014 || id_pc !== 32'd4) begin n_fail++; $display("FAIL first_word: got %h @%h expected e3a00014 @00000004", id_instr, id_pc); end
            end
        end
        n_checks++; if (imem_addr !== 32'd12 || fetch_count !== 16'd3) begin n_fail++; $display("FAIL seq_end: got addr %h cnt %0d expected 0000000c 3", imem_addr, fetch_count); end
    endtask

    task automatic test_freeze();
        logic [31:0] pc0, ipc0, ins0;
        logic [15:0] c0;
        pc0 = m_pc; ipc0 = m_id_pc; ins0 = m_id_instr; c0 = m_cnt;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 32'h0);
            n_checks++; if (imem_addr !== pc0 || id_pc !== ipc0 || id_instr !== ins0 || fetch_count !== c0 || id_valid !== 1'b1)
                begin n_fail++; $display("FAIL freeze_hold[%0d]: got %h/%h/%h/%0d expected %h/%h/%h/%0d", i, imem_addr, id_pc, id_instr, fetch_count, pc0, ipc0, ins0, c0); end
        end
        drive(1'b0, 1'b0, 32'h0);
        n_checks++; if (imem_addr !== pc0 + 32'd4 || id_pc !== pc0 + 32'd4 || fetch_count !== c0 + 16'd1)
            begin n_fail++; $display("FAIL freeze_release: got %h/%h/%0d expected %h/%h/%0d", imem_addr, id_pc, fetch_count, pc0 + 32'd4, pc0 + 32'd4, c0 + 16'd1); end
    endtask

    task automatic test_branch_freeze();
        logic [15:0] c0;
        c0 = m_cnt;
        drive(1'b1, 1'b1, 32'h70);
        n_checks++; if (imem_addr !== 32'h70 || id_valid !== 1'b0 || id_instr !== 32'h0 || fetch_count !== c0)
            begin n_fail++; $display("FAIL branch_flush: got %h/%b/%h/%0d expected 00000070/0/00000000/%0d", imem_addr, id_valid, id_instr, fetch_count, c0); end
        drive(1'b0, 1'b0, 32'h0);
        n_checks++; if (id_pc !== 32'h74 || id_valid !== 1'b1 || id_instr !== rom(32'h70))
            begin n_fail++; $display("FAIL branch_next: got %h/%b/%h expected 00000074/1/%h", id_pc, id_valid, id_instr, rom(32'h70)); end
    endtask

    task automatic test_align();
        drive(1'b0, 1'b1, 32'h93);
        n_checks++; if (imem_addr !== 32'h90) begin n_fail++; $display("FAIL align: got %h expected 00000090", imem_addr); end
    endtask

    task automatic test_random();
        logic f, b;
        logic [31:0] a;
        for (int i = 0; i < 300; i++) begin
            f = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 9) == 0);
            a = $urandom;
            drive(f, b, a);
            n_checks++;
            if (imem_addr !== m_pc || id_pc !== m_id_pc || id_instr !== m_id_instr || id_valid !== m_id_valid || fetch_count !== m_cnt)
                begin n_fail++; $display("FAIL random[%0d]: got %h/%h/%h/%b/%0d expected %h/%h/%h/%b/%0d", i, imem_addr, id_pc, id_instr, id_valid, fetch_count, m_pc, m_id_pc, m_id_instr, m_id_valid, m_cnt); end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        n_checks++; if (imem_addr_w !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_reset_pc: got %h expected fffffffc", imem_addr_w); end
        drive(1'b0, 1'b0, 32'h0);
        n_checks++; if (imem_addr_w !== 32'h0 || id_pc_w !== 32'h0 || id_valid_w !== 1'b1 || id_instr_w !== 32'h0 || fetch_count_w !== 16'd1)
            begin n_fail++; $display("FAIL wrap_fetch: got %h/%h/%b/%h/%0d expected 00000000/00000000/1/00000000/1", imem_addr_w, id_pc_w, id_valid_w, id_instr_w, fetch_count_w); end
    endtask

    task automatic test_reset_during_branch();
        repeat (3) drive(1'b0, 1'b0, 32'h0);
        freeze = 1'b0; branch_taken = 1'b1; branch_addr = 32'h200;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (imem_addr !== 32'h0 || id_pc !== 32'h0 || id_instr !== 32'h0 || id_valid !== 1'b0 || fetch_count !== 16'h0)
            begin n_fail++; $display("FAIL rst_in_branch: got %h/%h/%h/%b/%0d expected all zero", imem_addr, id_pc, id_instr, id_valid, fetch_count); end
        n_checks++; if (imem_addr_w !== 32'hFFFF_FFFC || id_valid_w !== 1'b0 || fetch_count_w !== 16'h0)
            begin n_fail++; $display("FAIL rst_in_branch_wrap: got %h/%b/%0d expected fffffffc/0/0", imem_addr_w, id_valid_w, fetch_count_w); end
        @(posedge clk); #1;
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_held_edge: got %h expected 00000000", imem_addr); end
        @(negedge clk);
        branch_taken = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_freeze();
        test_branch_freeze();
        test_align();
        test_random();
        test_wrap();
        test_reset_during_branch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
